// File: rtl/text_buffer_ctrl.sv
// Text buffer controller for the VGA text renderer: owns the character cells and
// the cursor, and runs terminal-style commands including multi-cycle clear and scroll.
module text_buffer_ctrl #(
  parameter int         CHARS = 256,
  parameter int         COLS  = 64,
  parameter logic [7:0] FILL  = 8'h20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [7:0]               cmd_data,
  output logic [7:0]               text [CHARS-1:0],
  output logic [$clog2(CHARS)-1:0] cursor,
  output logic                     busy
);

  localparam int CW = $clog2(CHARS);

  localparam logic [1:0] OP_PUTC    = 2'b00;
  localparam logic [1:0] OP_NEWLINE = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;
  localparam logic [1:0] OP_SETCUR  = 2'b11;

  localparam logic [CW-1:0] ZERO         = '0;
  localparam logic [CW-1:0] ONE          = CW'(1);
  localparam logic [CW-1:0] LAST_CELL    = CW'(CHARS - 1);
  localparam logic [CW-1:0] LAST_ROW     = CW'(CHARS - COLS);
  localparam logic [CW-1:0] COL_MASK     = CW'(COLS - 1);
  localparam logic [CW-1:0] ROW_STEP     = CW'(COLS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   idx;
  logic            accept;

  logic            wrEn;
  logic [CW-1:0]   wrAddr;
  logic [7:0]      wrData;

  // First cell of the row after the one holding pos.
  function automatic logic [CW-1:0] nextRowBase(input logic [CW-1:0] pos);
    return (pos | COL_MASK) + ONE;
  endfunction

  // Ready/busy are gated by reset so both read low while reset is held.
  assign cmd_ready = !reset && (state == IDLE);
  assign busy      = !reset && (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Single write port: selects the one cell (if any) updated this clock.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = idx;
    wrData = FILL;
    case (state)
      IDLE: begin
        if (accept && cmd_op == OP_PUTC) begin
          wrEn   = 1'b1;
          wrAddr = cursor;
          wrData = cmd_data;
        end
      end
      CLEAR: begin
        wrEn = 1'b1;
      end
      SCROLL: begin
        wrEn = 1'b1;
        // Ascending idx means text[idx+COLS] has not been overwritten yet.
        if (idx < LAST_ROW)
          wrData = text[idx + ROW_STEP];
      end
      default: begin
        wrEn = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHARS; i++)
        text[i] <= FILL;
    end else if (wrEn) begin
      text[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= ZERO;
      cursor <= ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_PUTC: begin
                if (cursor == LAST_CELL) begin
                  cursor <= LAST_ROW;
                  idx    <= ZERO;
                  state  <= SCROLL;
                end else begin
                  cursor <= cursor + ONE;
                end
              end
              OP_NEWLINE: begin
                if (cursor < LAST_ROW) begin
                  cursor <= nextRowBase(cursor);
                end else begin
                  cursor <= LAST_ROW;
                  idx    <= ZERO;
                  state  <= SCROLL;
                end
              end
              OP_CLEAR: begin
                cursor <= ZERO;
                idx    <= ZERO;
                state  <= CLEAR;
              end
              OP_SETCUR: begin
                cursor <= CW'(cmd_data);
              end
            endcase
          end
        end
        CLEAR, SCROLL: begin
          idx <= idx + ONE;
          if (idx == LAST_CELL)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed bench for text_buffer_ctrl: hand-computed buffer/cursor expectations
// checked with immediate assertions after each step.
module tb_text_buffer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] text [255:0];
  logic [7:0] cursor;
  logic       busy;

  logic [7:0] model [256];
  int checks = 0;
  int errors = 0;

  text_buffer_ctrl #(.CHARS(256), .COLS(64), .FILL(8'h20)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .text(text), .cursor(cursor), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int diffCells();
    int n = 0;
    for (int i = 0; i < 256; i++)
      if (text[i] !== model[i]) n++;
    return n;
  endfunction

  task automatic fillModel(input logic [7:0] v);
    for (int i = 0; i < 256; i++) model[i] = v;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic busyCycles(output int n);
    n = 0;
    while (busy && n < 400) begin
      n++;
      step();
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    fillModel(8'h20);
    repeat (3) step();
    chk("reset_ready", 32'(cmd_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cursor", 32'(cursor), 32'd0);
    chk("reset_cells", 32'(diffCells()), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Back-to-back PUTC
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h41;
    step();
    chk("putc_a_cell", 32'(text[0]), 32'h41);
    chk("putc_a_cursor", 32'(cursor), 32'd1);
    chk("putc_a_ready", 32'(cmd_ready), 32'd1);
    cmd_data = 8'h42;
    step();
    cmd_valid = 1'b0;
    chk("putc_b_cell", 32'(text[1]), 32'h42);
    chk("putc_b_cursor", 32'(cursor), 32'd2);
    chk("putc_b_ready", 32'(cmd_ready), 32'd1);
    model[0] = 8'h41; model[1] = 8'h42;
    chk("putc_others", 32'(diffCells()), 32'd0);

    // NEWLINE mid-buffer, then NEWLINE on last row triggers scroll
    issue(2'b11, 8'd70);
    chk("setcur_70", 32'(cursor), 32'd70);
    issue(2'b01, 8'h00);
    chk("newline_row1", 32'(cursor), 32'd128);
    chk("newline_ready", 32'(cmd_ready), 32'd1);
    issue(2'b11, 8'd200);
    issue(2'b01, 8'h00);
    chk("nl_scroll_cursor", 32'(cursor), 32'd192);
    chk("nl_scroll_ready", 32'(cmd_ready), 32'd0);
    busyCycles(n);
    chk("nl_scroll_len", 32'(n), 32'd256);
    chk("nl_scroll_ready_after", 32'(cmd_ready), 32'd1);
    fillModel(8'h20);
    chk("nl_scroll_cells", 32'(diffCells()), 32'd0);

    // Pattern fill text[i]=i, then PUTC at last cell wraps into scroll
    issue(2'b11, 8'd0);
    cmd_valid = 1'b1; cmd_op = 2'b00;
    for (int i = 0; i < 255; i++) begin
      cmd_data = 8'(i);
      step();
    end
    cmd_valid = 1'b0;
    chk("pattern_cursor", 32'(cursor), 32'd255);
    chk("pattern_cell", 32'(text[254]), 32'hFE);
    issue(2'b11, 8'd255);
    issue(2'b00, 8'h58);
    chk("wrap_cell255", 32'(text[255]), 32'h58);
    chk("wrap_cursor", 32'(cursor), 32'd192);
    chk("wrap_busy", 32'(busy), 32'd1);
    busyCycles(n);
    chk("wrap_scroll_len", 32'(n), 32'd256);
    for (int i = 0; i < 256; i++)
      model[i] = (i < 191) ? 8'(i + 64) : (i == 191) ? 8'h58 : 8'h20;
    chk("wrap_scroll_cells", 32'(diffCells()), 32'd0);
    chk("wrap_cell0", 32'(text[0]), 32'h40);
    chk("wrap_cell191", 32'(text[191]), 32'h58);
    chk("wrap_cursor_after", 32'(cursor), 32'd192);

    // CLEAR with PUTC held valid throughout busy
    issue(2'b10, 8'h00);
    chk("clear_cursor", 32'(cursor), 32'd0);
    chk("clear_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h77;
    busyCycles(n);
    chk("clear_len", 32'(n), 32'd256);
    chk("clear_held_cursor", 32'(cursor), 32'd0);
    fillModel(8'h20);
    chk("clear_cells", 32'(diffCells()), 32'd0);
    step();
    cmd_valid = 1'b0;
    chk("held_putc_cell", 32'(text[0]), 32'h77);
    chk("held_putc_cursor", 32'(cursor), 32'd1);

    // Reset during scroll
    issue(2'b11, 8'd255);
    issue(2'b00, 8'h11);
    repeat (99) step();
    chk("mid_scroll_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    fillModel(8'h20);
    chk("abort_cells", 32'(diffCells()), 32'd0);
    chk("abort_cursor", 32'(cursor), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_ready_release", 32'(cmd_ready), 32'd1);
    issue(2'b00, 8'h33);
    chk("abort_putc_cell", 32'(text[0]), 32'h33);
    chk("abort_putc_cursor", 32'(cursor), 32'd1);
    model[0] = 8'h33;

    // Idle inputs with cmd_valid low
    for (int i = 0; i < 50; i++) begin
      cmd_op   = 2'($urandom_range(0, 3));
      cmd_data = 8'($urandom_range(0, 255));
      step();
    end
    chk("idle_cursor", 32'(cursor), 32'd1);
    chk("idle_cells", 32'(diffCells()), 32'd0);
    chk("idle_ready", 32'(cmd_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
